// File: rtl/mavg_ctrl.sv
// mavg_ctrl: sequencing controller for the moving-average filter.
// Admits one sample at a time, waits out the filter latency,
// suppresses results until the window has filled, and applies
// window changes at sample boundaries by flushing the filter.
//
// Ports:
//   clk, nRST             clock, async active-low reset
//   cfg_win, cfg_load     window request and one-cycle load strobe
//   up_valid/ready/data   upstream sample handshake
//   dn_valid/ready/data   downstream result handshake
//   f_data_in, f_e_in     sample and enable pulse to the filter
//   f_mask, f_nrst        window size and active-low flush to filter
//   f_data_out            result from the filter
//   win_full              window has filled since the last flush
//   busy                  controller is not idle
module mavg_ctrl #(
    parameter int WIDTH       = 10,
    parameter int MAX_WIN     = 256,
    parameter int DEF_WIN     = 4,
    parameter int FILTER_LAT  = 1,
    parameter int FLUSH_CYC   = 2,
    parameter bit EMIT_WARMUP = 1'b0
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic [9:0]       cfg_win,
    input  logic             cfg_load,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data,
    output logic [WIDTH-1:0] f_data_in,
    output logic             f_e_in,
    output logic [9:0]       f_mask,
    output logic             f_nrst,
    input  logic [WIDTH-1:0] f_data_out,
    output logic             win_full,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_FLUSH,
        S_IDLE,
        S_WAIT,
        S_OUT
    } state_t;

    localparam int         CW    = 8;
    localparam logic [9:0] MAXW  = 10'(MAX_WIN);
    localparam logic [9:0] DEFW  = 10'(DEF_WIN);
    localparam logic [CW-1:0] FLUSH_LD = CW'(FLUSH_CYC);
    localparam logic [CW-1:0] LAT_LD   = CW'(FILTER_LAT);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [9:0]       r_win;
    logic [9:0]       r_pend_win;
    logic             r_pend;
    logic [9:0]       r_fill;
    logic             r_f_nrst;
    logic             r_f_e;
    logic [WIDTH-1:0] r_f_din;
    logic             r_dn_valid;
    logic [WIDTH-1:0] r_dn_data;

    logic             w_up_ready;
    logic             w_accept;
    logic [9:0]       w_cfg_clamp;
    logic [9:0]       w_fill_nxt;

    always_comb begin
        w_cfg_clamp = cfg_win;
        if (cfg_win == 10'd0)
            w_cfg_clamp = 10'd1;
        else if (cfg_win > MAXW)
            w_cfg_clamp = MAXW;
    end

    // A load in flight blocks admission so the new window
    // is applied before the next sample enters the filter.
    assign w_up_ready = (r_state == S_IDLE) & ~r_pend & ~cfg_load;
    assign w_accept   = up_valid & w_up_ready;
    assign w_fill_nxt = (r_fill >= r_win) ? r_win : r_fill + 10'd1;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state    <= S_FLUSH;
            r_cnt      <= FLUSH_LD;
            r_win      <= DEFW;
            r_pend_win <= DEFW;
            r_pend     <= 1'b0;
            r_fill     <= 10'd0;
            r_f_nrst   <= 1'b0;
            r_f_e      <= 1'b0;
            r_f_din    <= '0;
            r_dn_valid <= 1'b0;
            r_dn_data  <= '0;
        end else begin
            r_f_e <= 1'b0;
            if (cfg_load) begin
                r_pend     <= 1'b1;
                r_pend_win <= w_cfg_clamp;
            end
            case (r_state)
                S_FLUSH: begin
                    if (r_cnt <= CW'(1)) begin
                        r_state  <= S_IDLE;
                        r_f_nrst <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_IDLE: begin
                    if (r_pend) begin
                        r_state  <= S_FLUSH;
                        r_cnt    <= FLUSH_LD;
                        r_f_nrst <= 1'b0;
                        r_win    <= r_pend_win;
                        r_fill   <= 10'd0;
                        // a same-cycle load stays pending
                        if (!cfg_load)
                            r_pend <= 1'b0;
                    end else if (w_accept) begin
                        r_f_din <= up_data;
                        r_f_e   <= 1'b1;
                        r_fill  <= w_fill_nxt;
                        r_cnt   <= LAT_LD;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_dn_data <= f_data_out;
                        if (r_fill == r_win || EMIT_WARMUP) begin
                            r_dn_valid <= 1'b1;
                            r_state    <= S_OUT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_OUT: begin
                    if (dn_ready) begin
                        r_dn_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_FLUSH;
            endcase
        end
    end

    assign up_ready  = w_up_ready;
    assign dn_valid  = r_dn_valid;
    assign dn_data   = r_dn_data;
    assign f_data_in = r_f_din;
    assign f_e_in    = r_f_e;
    assign f_mask    = r_win;
    assign f_nrst    = r_f_nrst;
    assign win_full  = (r_fill == r_win);
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mavg_ctrl.sv
// tb_mavg_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level window model.
module tb_mavg_ctrl;

    localparam int  DEF  = 4;
    localparam int  MAXW = 256;
    localparam bit  EMIT = 1'b0;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic [9:0] cfg_win = '0;
    logic       cfg_load = 1'b0;
    logic       up_valid = 1'b0;
    logic       up_ready;
    logic [9:0] up_data = '0;
    logic       dn_valid;
    logic       dn_ready = 1'b1;
    logic [9:0] dn_data;
    logic [9:0] f_data_in;
    logic       f_e_in;
    logic [9:0] f_mask;
    logic       f_nrst;
    logic [9:0] f_data_out;
    logic       win_full;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    int n_dv   = 0;
    int n_flush = 0;

    always #5 clk = ~clk;

    mavg_ctrl #(
        .WIDTH(10), .MAX_WIN(MAXW), .DEF_WIN(DEF),
        .FILTER_LAT(1), .FLUSH_CYC(2), .EMIT_WARMUP(EMIT)
    ) dut (
        .clk(clk), .nRST(nRST),
        .cfg_win(cfg_win), .cfg_load(cfg_load),
        .up_valid(up_valid), .up_ready(up_ready),
        .up_data(up_data),
        .dn_valid(dn_valid), .dn_ready(dn_ready),
        .dn_data(dn_data),
        .f_data_in(f_data_in), .f_e_in(f_e_in),
        .f_mask(f_mask), .f_nrst(f_nrst),
        .f_data_out(f_data_out),
        .win_full(win_full), .busy(busy)
    );

    // filter stub: one-cycle latency, result = sample + 3
    always @(posedge clk) begin
        if (!f_nrst)
            f_data_out <= '0;
        else if (f_e_in)
            f_data_out <= f_data_in + 10'd3;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampw(input int w);
        if (w == 0) return 1;
        if (w > MAXW) return MAXW;
        return w;
    endfunction

    // ---------------- reference model / monitor ----------------
    int   q[$];
    int   m_win, m_pend_win, m_fill, m_exp;
    bit   m_pend;
    bit   r_acc, r_load;
    int   r_data, r_cfg;
    bit   p_fn, p_dv, p_rdy;
    int   p_dd;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!nRST) begin
                q.delete();
                m_win = DEF; m_pend_win = DEF;
                m_fill = 0; m_pend = 0;
                r_acc = 0; r_load = 0;
                p_fn = 0; p_dv = 0; p_rdy = 0; p_dd = 0;
            end else begin
                // effects of the edge just passed
                if (p_fn && !f_nrst) begin
                    n_flush++;
                    m_win  = m_pend_win;
                    m_fill = 0;
                    m_pend = 0;
                end
                if (r_load) begin
                    m_pend     = 1;
                    m_pend_win = clampw(r_cfg);
                end
                chk("fe_pulse", int'(f_e_in), int'(r_acc));
                if (r_acc) begin
                    chk("f_din", int'(f_data_in), r_data);
                    m_fill = (m_fill + 1 > m_win) ? m_win : m_fill + 1;
                    if (m_fill == m_win || EMIT)
                        q.push_back((r_data + 3) % 1024);
                end
                if (p_dv && !p_rdy) begin
                    chk("hold_v", int'(dn_valid), 1);
                    chk("hold_d", int'(dn_data), p_dd);
                end
                if (dn_valid) n_dv++;
                if (dn_valid && dn_ready) begin
                    chk("dn_expected", int'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        m_exp = q.pop_front();
                        chk("dn_data", int'(dn_data), m_exp);
                    end
                end
                // events at the coming edge
                r_acc  = up_valid && up_ready;
                r_data = int'(up_data);
                r_load = cfg_load;
                r_cfg  = int'(cfg_win);
                if (r_acc) begin
                    chk("acc_pend", int'(m_pend), 0);
                    chk("acc_mask", int'(f_mask), m_win);
                    chk("acc_full", int'(win_full), int'(m_fill == m_win));
                end
                if (cfg_load) chk("ld_block", int'(up_ready), 0);
                p_fn = f_nrst; p_dv = dn_valid;
                p_rdy = dn_ready; p_dd = int'(dn_data);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send(input logic [9:0] d);
        int n;
        n = 0;
        @(negedge clk);
        up_valid = 1'b1;
        up_data  = d;
        #1;
        while (!up_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("send_rdy", int'(up_ready), 1);
        @(negedge clk);
        up_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        #1;
        while (!up_ready && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk("rdy_wait", int'(up_ready), 1);
    endtask

    int dv0, fl0, k;

    initial begin
        // reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_fnrst", int'(f_nrst), 0);
        chk("rst_fe", int'(f_e_in), 0);
        chk("rst_fdin", int'(f_data_in), 0);
        chk("rst_mask", int'(f_mask), DEF);
        chk("rst_dv", int'(dn_valid), 0);
        chk("rst_dd", int'(dn_data), 0);
        chk("rst_wf", int'(win_full), 0);
        chk("rst_ur", int'(up_ready), 0);
        chk("rst_busy", int'(busy), 1);
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk); #1;
        chk("rel1_fnrst", int'(f_nrst), 0);
        chk("rel1_ur", int'(up_ready), 0);
        @(negedge clk); #1;
        chk("rel2_fnrst", int'(f_nrst), 1);
        chk("rel2_ur", int'(up_ready), 1);
        chk("rel2_mask", int'(f_mask), DEF);

        // warm-up suppression
        dv0 = n_dv;
        repeat (3) send(10'd4);
        send(10'd4);
        #1;
        chk("warm_sup", n_dv - dv0, 0);
        chk("warm_fe", int'(f_e_in), 1);
        @(negedge clk); #1;
        chk("warm_dv1", int'(dn_valid), 0);
        @(negedge clk); #1;
        chk("warm_dv2", int'(dn_valid), 1);
        chk("warm_dd", int'(dn_data), 7);
        chk("warm_wf", int'(win_full), 1);

        // backpressure
        @(negedge clk);
        dn_ready = 1'b0;
        send(10'd100);
        @(negedge clk);
        @(negedge clk); #1;
        up_valid = 1'b1;
        up_data  = 10'd55;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_dv", int'(dn_valid), 1);
            chk("bp_dd", int'(dn_data), 103);
            chk("bp_ur", int'(up_ready), 0);
            chk("bp_fe", int'(f_e_in), 0);
            @(negedge clk);
        end
        up_valid = 1'b0;
        dn_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_idle", int'(busy), 0);
        chk("bp_dv0", int'(dn_valid), 0);

        // config mid-flight
        dn_ready = 1'b0;
        fl0 = n_flush;
        send(10'd5);
        cfg_load = 1'b1;
        cfg_win  = 10'd8;
        @(negedge clk);
        cfg_load = 1'b0;
        @(negedge clk);
        cfg_load = 1'b1;
        cfg_win  = 10'd16;
        #1;
        chk("cm_dv", int'(dn_valid), 1);
        chk("cm_mask_old", int'(f_mask), DEF);
        @(negedge clk);
        cfg_load = 1'b0;
        dn_ready = 1'b1;
        @(negedge clk); #1;
        chk("cm_idle", int'(busy), 0);
        chk("cm_mask_hold", int'(f_mask), DEF);
        @(negedge clk); #1;
        chk("cm_fnrst", int'(f_nrst), 0);
        chk("cm_mask", int'(f_mask), 16);
        chk("cm_wf", int'(win_full), 0);
        repeat (4) @(negedge clk);
        #1;
        chk("cm_one_flush", n_flush - fl0, 1);
        chk("cm_fnrst1", int'(f_nrst), 1);

        // clamp and collision
        @(negedge clk);
        up_valid = 1'b1;
        up_data  = 10'd50;
        cfg_load = 1'b1;
        cfg_win  = 10'd0;
        #1;
        chk("col_ur", int'(up_ready), 0);
        @(negedge clk);
        cfg_load = 1'b0;
        up_valid = 1'b0;
        #1;
        chk("col_fe", int'(f_e_in), 0);
        @(negedge clk); #1;
        chk("clamp0_mask", int'(f_mask), 1);
        chk("clamp0_fnrst", int'(f_nrst), 0);
        wait_ready();
        send(10'd20);
        #1;
        chk("w1_fe", int'(f_e_in), 1);
        @(negedge clk); #1;
        chk("w1_dv1", int'(dn_valid), 0);
        @(negedge clk); #1;
        chk("w1_dv2", int'(dn_valid), 1);
        chk("w1_dd", int'(dn_data), 23);
        chk("w1_wf", int'(win_full), 1);

        // async reset during WAIT
        @(negedge clk);
        dv0 = n_dv;
        send(10'd9);
        #3;
        nRST = 1'b0;
        #1;
        chk("ar_fnrst", int'(f_nrst), 0);
        chk("ar_mask", int'(f_mask), DEF);
        chk("ar_dv", int'(dn_valid), 0);
        chk("ar_fe", int'(f_e_in), 0);
        chk("ar_busy", int'(busy), 1);
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        wait_ready();
        chk("ar_no_dv", n_dv - dv0, 0);
        chk("ar_mask2", int'(f_mask), DEF);

        // clamp high
        @(negedge clk);
        cfg_load = 1'b1;
        cfg_win  = 10'd300;
        @(negedge clk);
        cfg_load = 1'b0;
        wait_ready();
        chk("clamp_hi", int'(f_mask), MAXW);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            up_valid = ($urandom_range(0, 2) != 0);
            up_data  = 10'($urandom);
            dn_ready = ($urandom_range(0, 3) != 0);
            cfg_load = ($urandom_range(0, 59) == 0);
            k = $urandom_range(0, 9);
            cfg_win  = (k == 0) ? 10'($urandom) : 10'(k - 1);
        end
        @(negedge clk);
        up_valid = 1'b0;
        cfg_load = 1'b0;
        dn_ready = 1'b1;
        repeat (30) @(negedge clk);
        #3;
        chk("drain_q", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
